// File: rtl/jk_serial_tx_if.sv
// Transmit-side bundle for jk_serial_tx: word handshake plus serial line and frame status.
// Handshake: a word transfers on a posedge where tx_valid and tx_ready are both 1; the master
// holds tx_data stable with tx_valid, and the slave ignores both whenever tx_ready is 0.
interface jk_serial_tx_if;
  logic       tx_valid;
  logic [3:0] tx_data;
  logic       tx_ready;
  logic       c;
  logic       busy;
  logic       done;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  c,
    input  busy,
    input  done
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output c,
    output busy,
    output done
  );
endinterface

// File: rtl/jk_serial_tx.sv
// Serializes a 4-bit word into a START / D0..D3 / [PARITY] / STOP frame on line c.
// The FSM state register is made of JK flip-flops with asynchronous active-low clear.
module jk_serial_tx_jkff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_serial_tx #(
  parameter int PARITY_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  jk_serial_tx_if.slave   bus,
  output logic [2:0]      state_dbg
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] state_bits;
  logic [2:0] next_bits;
  logic [1:0] idx;
  logic [3:0] hold;
  logic       tx_ready;
  logic       accept;

  assign state     = state_t'(state_bits);
  assign next_bits = state_next;
  assign state_dbg = state_bits;

  // Each JK cell is steered to the next-state bit: set when it must rise, clear when it must fall.
  for (genvar i = 0; i < 3; i++) begin : g_state_jk
    jk_serial_tx_jkff u_jk (
      .clk (clk),
      .rst (rst),
      .j   (next_bits[i] & ~state_bits[i]),
      .k   (~next_bits[i] & state_bits[i]),
      .q   (state_bits[i])
    );
  end

  assign tx_ready = (state == IDLE) || (state == STOP);
  assign accept   = bus.tx_valid && tx_ready;

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = accept ? START : IDLE;
      START:   state_next = DATA;
      DATA: begin
        if (idx == 2'd3) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        else             state_next = DATA;
      end
      PARITY:  state_next = STOP;
      STOP:    state_next = accept ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= 2'd0;
      hold <= 4'd0;
    end else begin
      if (accept) hold <= bus.tx_data;
      if (state == DATA) idx <= idx + 2'd1;
      else               idx <= 2'd0;
    end
  end

  // Line and status decode only from registered state, index and holding register.
  always_comb begin
    bus.c        = 1'b0;
    bus.busy     = (state != IDLE);
    bus.done     = (state == STOP);
    bus.tx_ready = tx_ready;
    case (state)
      START:   bus.c = 1'b1;
      DATA:    bus.c = hold[idx];
      PARITY:  bus.c = ^hold;
      default: bus.c = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_jk_serial_tx.sv
// Directed bench for jk_serial_tx: per-cycle expected {c,busy,done,tx_ready} records are queued
// when a word is driven and popped as the DUT steps through the frame.
module tb_jk_serial_tx;
  logic clk;
  logic rst;
  logic [2:0] state_p;
  logic [2:0] state_n;
  int vec_cnt;
  int miss_cnt;
  logic [3:0] exp_q[$];

  jk_serial_tx_if bus_p ();
  jk_serial_tx_if bus_n ();

  jk_serial_tx #(.PARITY_EN(1)) dut_p (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_p),
    .state_dbg (state_p)
  );

  jk_serial_tx #(.PARITY_EN(0)) dut_n (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_n),
    .state_dbg (state_n)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] obs(input bit sel);
    if (sel) return {bus_n.c, bus_n.busy, bus_n.done, bus_n.tx_ready};
    else     return {bus_p.c, bus_p.busy, bus_p.done, bus_p.tx_ready};
  endfunction

  task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      miss_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // drivers
  task automatic drive(input bit sel, input logic v, input logic [3:0] d);
    if (sel) begin
      bus_n.tx_valid = v;
      bus_n.tx_data  = d;
    end else begin
      bus_p.tx_valid = v;
      bus_p.tx_data  = d;
    end
  endtask

  // frame model: START=1, data LSB first, optional even parity, STOP=0 with done and ready
  task automatic push_frame(input logic [3:0] d, input bit par);
    exp_q.push_back(4'b1100);
    for (int i = 0; i < 4; i++) exp_q.push_back({d[i], 3'b100});
    if (par) exp_q.push_back({^d, 3'b100});
    exp_q.push_back(4'b0111);
  endtask

  task automatic push_idle();
    exp_q.push_back(4'b0001);
  endtask

  // scoreboard: one popped record per clock
  task automatic drain(input bit sel, input int n, input string tag);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $error("FAIL %s observed=%b expected=<empty queue>", tag, obs(sel));
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s[%0d]", tag, i), obs(sel), e);
      end
    end
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_p", obs(1'b0), 4'b0001);
    chk("reset_n", obs(1'b1), 4'b0001);
    chk("reset_state_p", {1'b0, state_p}, 4'b0000);

    // 4'b1011 accepted on the first edge after reset release
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'b1011);
    push_frame(4'b1011, 1'b1);
    drain(1'b0, 1, "f_b");
    drive(1'b0, 1'b0, 4'h0);
    drain(1'b0, 6, "f_b");
    push_idle();
    drain(1'b0, 1, "f_b_idle");

    // all-zero word
    drive(1'b0, 1'b1, 4'h0);
    push_frame(4'h0, 1'b1);
    drain(1'b0, 1, "f_0");
    drive(1'b0, 1'b0, 4'h0);
    drain(1'b0, 6, "f_0");
    push_idle();
    push_idle();
    drain(1'b0, 2, "f_0_idle");

    // back-to-back A then 5 with tx_valid held high
    drive(1'b0, 1'b1, 4'hA);
    push_frame(4'hA, 1'b1);
    drain(1'b0, 1, "b2b_a");
    drive(1'b0, 1'b1, 4'h5);
    drain(1'b0, 5, "b2b_a");
    push_frame(4'h5, 1'b1);
    drain(1'b0, 2, "b2b_a5");
    drive(1'b0, 1'b0, 4'h0);
    drain(1'b0, 6, "b2b_5");
    push_idle();
    drain(1'b0, 1, "b2b_idle");

    // 4'h3 with a competing request for 4'hF during the DATA cycles
    drive(1'b0, 1'b1, 4'h3);
    push_frame(4'h3, 1'b1);
    drain(1'b0, 1, "ign_3");
    drive(1'b0, 1'b1, 4'hF);
    drain(1'b0, 4, "ign_3");
    drive(1'b0, 1'b0, 4'h0);
    drain(1'b0, 2, "ign_3");
    push_idle();
    push_idle();
    drain(1'b0, 2, "ign_idle");

    // parity disabled instance, 4'b0110
    chk("n_idle", obs(1'b1), 4'b0001);
    drive(1'b1, 1'b1, 4'b0110);
    push_frame(4'b0110, 1'b0);
    drain(1'b1, 1, "np_6");
    drive(1'b1, 1'b0, 4'h0);
    drain(1'b1, 5, "np_6");
    push_idle();
    drain(1'b1, 1, "np_idle");

    // reset pulse in the second DATA cycle
    drive(1'b0, 1'b1, 4'h9);
    push_frame(4'h9, 1'b1);
    drain(1'b0, 1, "rst_9");
    drive(1'b0, 1'b0, 4'h0);
    drain(1'b0, 2, "rst_9");
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    chk("rst_async", obs(1'b0), 4'b0001);
    chk("rst_async_state", {1'b0, state_p}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_release", obs(1'b0), 4'b0001);
    drive(1'b0, 1'b1, 4'h1);
    push_frame(4'h1, 1'b1);
    drain(1'b0, 1, "rst_1");
    drive(1'b0, 1'b0, 4'h0);
    drain(1'b0, 6, "rst_1");
    push_idle();
    drain(1'b0, 1, "rst_1_idle");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
